// File: rtl/clk_div_pkg.sv
// Shared types and reset defaults for the multi-channel clock divider.
package clk_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } chan_state_t;

  localparam int DEF_DIV  = 1;
  localparam int DEF_HIGH = 1;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, run/stop state, shadow config and output flops.
module clk_div_chan #(
  parameter int CW       = 8,
  parameter int DEF_DIV  = 1,
  parameter int DEF_HIGH = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          sync_start,
  input  logic          wr,
  input  logic [CW-1:0] wr_div,
  input  logic [CW-1:0] wr_high,
  output logic          pending,
  output logic          clk_out,
  output logic          tick,
  output logic [1:0]    dbg_state
);
  import clk_div_pkg::*;

  chan_state_t   st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] div_q, div_d, high_q, high_d;
  logic [CW-1:0] sdiv_q, sdiv_d, shigh_q, shigh_d;
  logic          pend_q, pend_d;
  logic          running, boundary, running_d;

  always_comb begin
    st_d     = st_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    high_d   = high_q;
    sdiv_d   = sdiv_q;
    shigh_d  = shigh_q;
    pend_d   = pend_q;
    running  = (st_q != ST_IDLE);
    boundary = running && (cnt_q == div_q);

    if (sync_start && en) begin
      st_d  = ST_RUN;
      cnt_d = '0;
      if (pend_q) begin
        div_d  = sdiv_q;
        high_d = shigh_q;
        pend_d = 1'b0;
      end
    end else begin
      unique case (st_q)
        ST_IDLE: begin
          cnt_d = '0;
          // A write that landed on the final STOP boundary is still pending here
          if (pend_q) begin
            div_d  = sdiv_q;
            high_d = shigh_q;
            pend_d = 1'b0;
          end
          if (en) st_d = ST_RUN;
        end
        ST_RUN, ST_STOP: begin
          cnt_d = boundary ? '0 : cnt_q + 1'b1;
          if (boundary && pend_q) begin
            div_d  = sdiv_q;
            high_d = shigh_q;
            pend_d = 1'b0;
          end
          if (en)            st_d = ST_RUN;
          else if (boundary) st_d = ST_IDLE;
          else               st_d = ST_STOP;
        end
        default: begin
          st_d  = ST_IDLE;
          cnt_d = '0;
        end
      endcase
    end

    // Running channels only change config at a period boundary, so no runt pulses
    if (wr) begin
      if (st_q == ST_IDLE) begin
        div_d  = wr_div;
        high_d = wr_high;
      end else begin
        sdiv_d  = wr_div;
        shigh_d = wr_high;
        pend_d  = 1'b1;
      end
    end

    running_d = (st_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= ST_IDLE;
      cnt_q   <= '0;
      div_q   <= CW'(DEF_DIV);
      high_q  <= CW'(DEF_HIGH);
      sdiv_q  <= CW'(DEF_DIV);
      shigh_q <= CW'(DEF_HIGH);
      pend_q  <= 1'b0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      high_q  <= high_d;
      sdiv_q  <= sdiv_d;
      shigh_q <= shigh_d;
      pend_q  <= pend_d;
      clk_out <= running_d && (cnt_d < high_d);
      tick    <= running_d && (cnt_d == '0);
    end
  end

  assign pending   = pend_q;
  assign dbg_state = st_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: config decode, ready mux and channel array.
module clk_div_multi #(
  parameter int  NCH      = 4,
  parameter int  CW       = 8,
  parameter int  DEF_DIV  = clk_div_pkg::DEF_DIV,
  parameter int  DEF_HIGH = clk_div_pkg::DEF_HIGH,
  localparam int CHW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NCH-1:0]        en,
  input  logic                  sync_start,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CHW-1:0]        cfg_ch,
  input  logic [CW-1:0]         cfg_div,
  input  logic [CW-1:0]         cfg_high,
  output logic [NCH-1:0]        clk_out,
  output logic [NCH-1:0]        tick,
  output logic [NCH-1:0][1:0]   dbg_state
);

  logic [NCH-1:0] pending;
  logic [NCH-1:0] wr;

  // Handshake: a config word transfers on a clock edge where cfg_valid && cfg_ready.
  // cfg_ready drops only while the addressed channel holds an unapplied shadow;
  // out-of-range channels are always ready and their writes are dropped.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (cfg_ch == CHW'(i)) cfg_ready = !pending[i];
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    assign wr[i] = cfg_valid && cfg_ready && (cfg_ch == CHW'(i));

    clk_div_chan #(
      .CW       (CW),
      .DEF_DIV  (DEF_DIV),
      .DEF_HIGH (DEF_HIGH)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en[i]),
      .sync_start (sync_start),
      .wr         (wr[i]),
      .wr_div     (cfg_div),
      .wr_high    (cfg_high),
      .pending    (pending[i]),
      .clk_out    (clk_out[i]),
      .tick       (tick[i]),
      .dbg_state  (dbg_state[i])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed scoreboard bench for clk_div_multi (five channels so cfg_ch can go out of range).
module tb_clk_div_multi;

  localparam int NCH = 5;
  localparam int CW  = 8;
  localparam int CHW = 3;
  localparam int W   = 2;

  logic                clk;
  logic                rst_n;
  logic [NCH-1:0]      en;
  logic                sync_start;
  logic                cfg_valid;
  logic                cfg_ready;
  logic [CHW-1:0]      cfg_ch;
  logic [CW-1:0]       cfg_div;
  logic [CW-1:0]       cfg_high;
  logic [NCH-1:0]      clk_out;
  logic [NCH-1:0]      tick;
  logic [NCH-1:0][1:0] dbg_state;

  logic [W-1:0] exp_q[$];
  int n_assert;
  int n_fail;

  clk_div_multi #(.NCH(NCH), .CW(CW), .DEF_DIV(1), .DEF_HIGH(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .sync_start (sync_start),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_div    (cfg_div),
    .cfg_high   (cfg_high),
    .clk_out    (clk_out),
    .tick       (tick),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // driver / checker tasks
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic co, input logic tk);
    exp_q.push_back({co, tk});
  endtask

  task automatic drain(input int ch, input int n, input string tag);
    logic [W-1:0] e;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        n_assert++;
        n_fail++;
        $error("FAIL %s: observed empty queue expected entry", tag);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("%s[%0d]", tag, k), 32'({clk_out[ch], tick[ch]}), 32'(e));
      end
    end
  endtask

  task automatic cfg_write(input int ch, input int dv, input int hi);
    cfg_valid = 1'b1;
    cfg_ch    = CHW'(ch);
    cfg_div   = CW'(dv);
    cfg_high  = CW'(hi);
  endtask

  // stimulus
  initial begin
    int guard;
    n_assert   = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    en         = '0;
    sync_start = 1'b0;
    cfg_valid  = 1'b0;
    cfg_ch     = '0;
    cfg_div    = '0;
    cfg_high   = '0;

    repeat (2) @(negedge clk);
    check("rst_clk_out", 32'(clk_out), 0);
    check("rst_tick", 32'(tick), 0);
    check("rst_ready", 32'(cfg_ready), 1);
    check("rst_state", 32'(dbg_state), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_clk_out", 32'(clk_out), 0);

    // defaults: divide by two on ch0
    en[0] = 1'b1;
    repeat (3) begin push(1, 1); push(0, 0); end
    drain(0, 6, "ch0_default");

    // out-of-range channel is always ready
    cfg_write(6, 0, 0);
    check("oor_ready", 32'(cfg_ready), 1);
    @(negedge clk);
    cfg_valid = 1'b0;

    // ch1 div=4 high=2 written while idle
    cfg_write(1, 4, 2);
    check("idle_wr_ready", 32'(cfg_ready), 1);
    @(negedge clk);
    cfg_valid = 1'b0;
    en[1] = 1'b1;
    repeat (2) begin push(1, 1); push(1, 0); push(0, 0); push(0, 0); push(0, 0); end
    drain(1, 10, "ch1_p5");

    // mid-period rewrite to div=2 high=1
    push(1, 1); push(1, 0);
    drain(1, 2, "ch1_pre");
    cfg_write(1, 2, 1);
    check("mid_wr_ready", 32'(cfg_ready), 1);
    push(0, 0); push(0, 0); push(0, 0);
    push(1, 1); push(0, 0); push(0, 0);
    push(1, 1); push(0, 0); push(0, 0);
    drain(1, 1, "ch1_old_a");
    cfg_valid = 1'b0;
    check("pend_ready_a", 32'(cfg_ready), 0);
    drain(1, 1, "ch1_old_b");
    check("pend_ready_b", 32'(cfg_ready), 0);
    drain(1, 1, "ch1_old_c");
    check("pend_ready_c", 32'(cfg_ready), 0);
    drain(1, 1, "ch1_new_first");
    check("applied_ready", 32'(cfg_ready), 1);
    drain(1, 5, "ch1_p3");

    // write on the boundary cycle: old values finish the boundary
    cfg_write(1, 4, 2);
    push(1, 1); push(0, 0); push(0, 0); push(1, 1); push(1, 0);
    drain(1, 1, "bnd_wr_a");
    cfg_valid = 1'b0;
    check("bnd_pend_ready", 32'(cfg_ready), 0);
    drain(1, 4, "bnd_wr_b");

    // drop en at cnt=1: period completes then idle
    en[1] = 1'b0;
    repeat (5) push(0, 0);
    drain(1, 5, "stop_idle");
    check("stop_idle_state", 32'(dbg_state[1]), 0);

    // restart, drop at cnt=1, re-raise at cnt=3
    en[1] = 1'b1;
    push(1, 1); push(1, 0);
    drain(1, 2, "restart");
    en[1] = 1'b0;
    push(0, 0); push(0, 0);
    drain(1, 2, "stop_mid");
    check("stop_state", 32'(dbg_state[1]), 2);
    en[1] = 1'b1;
    push(0, 0); push(1, 1); push(1, 0); push(0, 0); push(0, 0); push(0, 0);
    drain(1, 6, "resume");
    check("run_state", 32'(dbg_state[1]), 1);

    // sync_start aligns ch0, ch1 and ch2
    cfg_write(2, 5, 3);
    @(negedge clk);
    cfg_valid = 1'b0;
    en[2] = 1'b1;
    push(1, 1);
    drain(2, 1, "ch2_start");
    repeat ($urandom_range(0, 3)) @(negedge clk);
    guard = 0;
    while (!(tick[0] && !tick[2] && clk_out[2]) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("sync_phase_found", 32'(guard < 20), 1);
    sync_start = 1'b1;
    @(negedge clk);
    sync_start = 1'b0;
    check("sync_tick", 32'(tick[2:0]), 32'h7);
    check("sync_clk_out", 32'(clk_out[2:0]), 32'h7);
    push(1, 0); push(1, 0); push(0, 0); push(0, 0); push(0, 0); push(1, 1);
    drain(2, 6, "ch2_after_sync");

    // high=0 constant low, then high=9 applied by sync_start
    cfg_write(3, 4, 0);
    @(negedge clk);
    cfg_valid = 1'b0;
    en[3] = 1'b1;
    push(0, 1); repeat (4) push(0, 0); push(0, 1);
    drain(3, 6, "ch3_high0");
    cfg_write(3, 4, 9);
    check("ch3_wr_ready", 32'(cfg_ready), 1);
    push(0, 0);
    drain(3, 1, "ch3_wr_cycle");
    cfg_valid = 1'b0;
    check("ch3_pend_ready", 32'(cfg_ready), 0);
    sync_start = 1'b1;
    push(1, 1);
    drain(3, 1, "ch3_sync_apply");
    sync_start = 1'b0;
    repeat (4) push(1, 0);
    push(1, 1);
    drain(3, 5, "ch3_high9");
    check("ch3_ready_after", 32'(cfg_ready), 1);

    // div=0: tick every cycle
    cfg_write(4, 0, 1);
    @(negedge clk);
    cfg_valid = 1'b0;
    en[4] = 1'b1;
    repeat (3) push(1, 1);
    drain(4, 3, "ch4_div0");

    // asynchronous reset mid-period
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_clk_out", 32'(clk_out), 0);
    check("async_rst_tick", 32'(tick), 0);
    check("async_rst_state", 32'(dbg_state), 0);
    en = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", 32'(clk_out), 0);
    en[3] = 1'b1;
    push(1, 1); push(0, 0); push(1, 1);
    drain(3, 3, "ch3_defaults");

    check("queue_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
